// File: rtl/alien_march_scheduler_pkg.sv
// Shared invaders definitions: FSM state encoding, default alien count and counter widths.
package invaders_pkg;

   localparam int ALIVE_W            = 6;
   localparam int WAVE_W             = 4;
   localparam int DEFAULT_NUM_ALIENS = 40;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_MARCH  = 3'd2,
      ST_PAUSED = 3'd3,
      ST_CLEAR  = 3'd4,
      ST_OVER   = 3'd5
   } state_t;

endpackage

// File: rtl/alien_march_scheduler_if.sv
// Game-side signal bundle for the march scheduler; MARCH_BEAT_EN adds the Beat output.
interface alien_march_scheduler_if;
   import invaders_pkg::*;

   logic               Frame_Tick;
   logic               Start;
   logic               Pause_Req;
   logic               Alien_Killed;
   logic               Reached_Bottom;
   logic               Step;
   logic               Formation_Reset;
   logic [ALIVE_W-1:0] AliveCount;
   logic [WAVE_W-1:0]  Wave;
   logic               Game_Over;
   logic               Marching;
`ifdef MARCH_BEAT_EN
   logic [1:0]         Beat;
`endif

   modport master (
      output Frame_Tick, Start, Pause_Req, Alien_Killed, Reached_Bottom,
`ifdef MARCH_BEAT_EN
      input  Beat,
`endif
      input  Step, Formation_Reset, AliveCount, Wave, Game_Over, Marching
   );

   modport slave (
      input  Frame_Tick, Start, Pause_Req, Alien_Killed, Reached_Bottom,
`ifdef MARCH_BEAT_EN
      output Beat,
`endif
      output Step, Formation_Reset, AliveCount, Wave, Game_Over, Marching
   );

endinterface

// File: rtl/alien_march_scheduler_period_calc.sv
// Frames-between-steps formula: PERIOD_MIN + (alive >> SPEED_SHIFT) - wave, clamped at PERIOD_MIN.
module march_period_calc
   import invaders_pkg::*;
#(
   parameter int PERIOD_MIN  = 2,
   parameter int SPEED_SHIFT = 1
) (
   input  logic [ALIVE_W-1:0] alive,
   input  logic [WAVE_W-1:0]  wave,
   output logic [7:0]         period
);

   logic signed [7:0] min_s;
   logic signed [7:0] alive_s;
   logic signed [7:0] wave_s;
   logic signed [7:0] raw_s;

   always_comb begin
      min_s   = signed'(8'(PERIOD_MIN));
      alive_s = signed'({2'b00, alive >> SPEED_SHIFT});
      wave_s  = signed'({4'b0000, wave});
      raw_s   = min_s + alive_s - wave_s;
      // Late waves drive the raw value negative; the signed compare catches that.
      period  = (raw_s < min_s) ? 8'(min_s) : 8'(raw_s);
   end

endmodule

// File: rtl/alien_march_scheduler.sv
// Alien formation march sequencer: wave FSM, frame counter, alive/wave counters.
// Optional macro MARCH_BEAT_EN adds the 2-bit Beat counter advanced on every Step.
module alien_march_scheduler
   import invaders_pkg::*;
#(
   parameter int NUM_ALIENS   = DEFAULT_NUM_ALIENS,
   parameter int PERIOD_MIN   = 2,
   parameter int SPEED_SHIFT  = 1,
   parameter int CLEAR_FRAMES = 90,
   parameter int MAX_WAVE     = 15
) (
   input logic                    Clk,
   input logic                    Reset_n,
   alien_march_scheduler_if.slave bus
);

   state_t             state_q, state_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic [ALIVE_W-1:0] alive_q, alive_d;
   logic [WAVE_W-1:0]  wave_q, wave_d;
   logic               step_q, step_d;
   logic               frst_q, frst_d;
   logic               over_q, over_d;
   logic               march_q, march_d;
   logic [7:0]         period;
   logic [7:0]         cnt_inc;
   logic               kill_ok;

   march_period_calc #(
      .PERIOD_MIN  (PERIOD_MIN),
      .SPEED_SHIFT (SPEED_SHIFT)
   ) u_period (
      .alive  (alive_q),
      .wave   (wave_q),
      .period (period)
   );

   assign cnt_inc = frame_cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      alive_d     = alive_q;
      wave_d      = wave_q;
      step_d      = 1'b0;
      kill_ok     = bus.Alien_Killed && (alive_q != '0);

      case (state_q)
         ST_IDLE: if (bus.Start) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_MARCH;
         ST_MARCH, ST_PAUSED: begin
            if (kill_ok) alive_d = alive_q - 1'b1;
            if (bus.Reached_Bottom) begin
               state_d = ST_OVER;
            end else if (alive_d == '0) begin
               state_d     = ST_CLEAR;
               frame_cnt_d = '0;
            end else if (state_q == ST_MARCH) begin
               // A tick coinciding with a pause request is dropped so the held count stays exact.
               if (bus.Pause_Req) begin
                  state_d = ST_PAUSED;
               end else if (bus.Frame_Tick) begin
                  if (cnt_inc >= period) begin
                     frame_cnt_d = '0;
                     step_d      = 1'b1;
                  end else begin
                     frame_cnt_d = cnt_inc;
                  end
               end
            end else if (!bus.Pause_Req) begin
               state_d = ST_MARCH;
            end
         end
         ST_CLEAR: begin
            if (bus.Frame_Tick) begin
               if (cnt_inc >= 8'(CLEAR_FRAMES)) begin
                  frame_cnt_d = '0;
                  wave_d      = (wave_q == WAVE_W'(MAX_WAVE)) ? wave_q : wave_q + 1'b1;
                  state_d     = ST_LOAD;
               end else begin
                  frame_cnt_d = cnt_inc;
               end
            end
         end
         ST_OVER: begin
            if (bus.Start) begin
               wave_d  = '0;
               state_d = ST_LOAD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Formation reload happens on entry to LOAD so AliveCount is already full during the pulse.
      if (state_d == ST_LOAD) begin
         alive_d     = ALIVE_W'(NUM_ALIENS);
         frame_cnt_d = '0;
      end

      frst_d  = (state_d == ST_LOAD);
      over_d  = (state_d == ST_OVER);
      march_d = (state_d == ST_MARCH);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= ST_IDLE;
         frame_cnt_q <= '0;
         alive_q     <= ALIVE_W'(NUM_ALIENS);
         wave_q      <= '0;
         step_q      <= 1'b0;
         frst_q      <= 1'b0;
         over_q      <= 1'b0;
         march_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         alive_q     <= alive_d;
         wave_q      <= wave_d;
         step_q      <= step_d;
         frst_q      <= frst_d;
         over_q      <= over_d;
         march_q     <= march_d;
      end
   end

   assign bus.Step            = step_q;
   assign bus.Formation_Reset = frst_q;
   assign bus.AliveCount      = alive_q;
   assign bus.Wave            = wave_q;
   assign bus.Game_Over       = over_q;
   assign bus.Marching        = march_q;

`ifdef MARCH_BEAT_EN
   logic [1:0] beat_q, beat_d;

   always_comb begin
      beat_d = beat_q;
      if (state_d == ST_LOAD) beat_d = '0;
      else if (step_d)        beat_d = beat_q + 2'd1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) beat_q <= '0;
      else          beat_q <= beat_d;
   end

   assign bus.Beat = beat_q;
`endif

endmodule

// File: tb/tb_alien_march_scheduler.sv
// Directed self-checking bench for alien_march_scheduler with default parameters.
module tb_alien_march_scheduler;

   logic Clk = 1'b0;
   logic Reset_n;
   int   checks = 0;
   int   errors = 0;
   int   step_cnt = 0;
   int   fr_cnt = 0;

   alien_march_scheduler_if dif ();

   alien_march_scheduler dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (dif)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      if (dif.Step === 1'b1) step_cnt++;
      if (dif.Formation_Reset === 1'b1) fr_cnt++;
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick(output logic stepped);
      dif.Frame_Tick = 1'b1;
      cyc();
      dif.Frame_Tick = 1'b0;
      stepped = dif.Step;
      cyc();
   endtask

   task automatic kill(input int n);
      for (int i = 0; i < n; i++) begin
         dif.Alien_Killed = 1'b1;
         cyc();
      end
      dif.Alien_Killed = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      dif.Frame_Tick = 1'b0; dif.Start = 1'b0; dif.Pause_Req = 1'b0;
      dif.Alien_Killed = 1'b0; dif.Reached_Bottom = 1'b0;
      cyc(); cyc();
      checks++; if (dif.Step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b expected 0", dif.Step); end
      checks++; if (dif.Formation_Reset !== 1'b0) begin errors++; $display("FAIL reset_frst: got %b expected 0", dif.Formation_Reset); end
      checks++; if (dif.AliveCount !== 6'd40) begin errors++; $display("FAIL reset_alive: got %0d expected 40", dif.AliveCount); end
      checks++; if (dif.Wave !== 4'd0) begin errors++; $display("FAIL reset_wave: got %0d expected 0", dif.Wave); end
      checks++; if (dif.Game_Over !== 1'b0) begin errors++; $display("FAIL reset_over: got %b expected 0", dif.Game_Over); end
      checks++; if (dif.Marching !== 1'b0) begin errors++; $display("FAIL reset_march: got %b expected 0", dif.Marching); end
      Reset_n = 1'b1;
      cyc();
   endtask

   task automatic test_start_period();
      int   s0, f0;
      logic s;
      f0 = fr_cnt;
      dif.Start = 1'b1;
      cyc();
      dif.Start = 1'b0;
      checks++; if (dif.Formation_Reset !== 1'b1) begin errors++; $display("FAIL load_frst: got %b expected 1", dif.Formation_Reset); end
      cyc();
      checks++; if (dif.Marching !== 1'b1) begin errors++; $display("FAIL march_enter: got %b expected 1", dif.Marching); end
      s0 = step_cnt;
      repeat (21) tick(s);
      checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL early_step: got %0d steps expected 0", step_cnt - s0); end
      tick(s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL step_tick22: got %b expected 1", s); end
      repeat (3) tick(s);
      checks++; if (step_cnt - s0 !== 1) begin errors++; $display("FAIL steps_25ticks: got %0d expected 1", step_cnt - s0); end
      checks++; if (fr_cnt - f0 !== 1) begin errors++; $display("FAIL frst_count: got %0d expected 1", fr_cnt - f0); end
   endtask

   task automatic test_fast_period();
      logic       s;
      logic [5:0] obs;
      kill(38);
      checks++; if (dif.AliveCount !== 6'd2) begin errors++; $display("FAIL alive_after38: got %0d expected 2", dif.AliveCount); end
      // Count sits at 3 from the earlier ticks, so the next tick reaches Period=3.
      tick(s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL fast_first: got %b expected 1", s); end
      for (int i = 0; i < 6; i++) begin
         tick(s);
         obs[i] = s;
      end
      checks++; if (obs !== 6'b100100) begin errors++; $display("FAIL period3_pattern: got %b expected 100100", obs); end
   endtask

   task automatic test_clear_wave();
      int   s0, f0;
      logic s;
      kill(2);
      checks++; if (dif.Marching !== 1'b0) begin errors++; $display("FAIL clear_enter: got %b expected 0", dif.Marching); end
      checks++; if (dif.AliveCount !== 6'd0) begin errors++; $display("FAIL clear_alive: got %0d expected 0", dif.AliveCount); end
      s0 = step_cnt;
      f0 = fr_cnt;
      repeat (89) tick(s);
      checks++; if (dif.Wave !== 4'd0 || fr_cnt - f0 !== 0) begin errors++; $display("FAIL clear_early: got wave %0d resets %0d expected 0 0", dif.Wave, fr_cnt - f0); end
      tick(s);
      checks++; if (dif.Wave !== 4'd1) begin errors++; $display("FAIL wave_inc: got %0d expected 1", dif.Wave); end
      checks++; if (fr_cnt - f0 !== 1) begin errors++; $display("FAIL clear_frst: got %0d expected 1", fr_cnt - f0); end
      checks++; if (dif.AliveCount !== 6'd40) begin errors++; $display("FAIL reload_alive: got %0d expected 40", dif.AliveCount); end
      checks++; if (dif.Marching !== 1'b1) begin errors++; $display("FAIL remarch: got %b expected 1", dif.Marching); end
      checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL clear_steps: got %0d expected 0", step_cnt - s0); end
   endtask

   task automatic test_wave_clamp();
      logic       s;
      logic [5:0] obs;
      for (int w = 0; w < 14; w++) begin
         kill(40);
         repeat (90) tick(s);
      end
      checks++; if (dif.Wave !== 4'd15) begin errors++; $display("FAIL wave15: got %0d expected 15", dif.Wave); end
      kill(40);
      repeat (90) tick(s);
      checks++; if (dif.Wave !== 4'd15) begin errors++; $display("FAIL wave_sat: got %0d expected 15", dif.Wave); end
      kill(20);
      checks++; if (dif.AliveCount !== 6'd20) begin errors++; $display("FAIL alive20: got %0d expected 20", dif.AliveCount); end
      for (int i = 0; i < 6; i++) begin
         tick(s);
         obs[i] = s;
      end
      checks++; if (obs !== 6'b101010) begin errors++; $display("FAIL clamp_pattern: got %b expected 101010", obs); end
   endtask

   task automatic test_pause();
      int   s0;
      logic s;
      tick(s);
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL prepause_tick: got %b expected 0", s); end
      dif.Pause_Req = 1'b1;
      cyc();
      checks++; if (dif.Marching !== 1'b0) begin errors++; $display("FAIL paused: got %b expected 0", dif.Marching); end
      s0 = step_cnt;
      repeat (50) tick(s);
      kill(1);
      checks++; if (step_cnt - s0 !== 0) begin errors++; $display("FAIL pause_steps: got %0d expected 0", step_cnt - s0); end
      checks++; if (dif.AliveCount !== 6'd19) begin errors++; $display("FAIL pause_kill: got %0d expected 19", dif.AliveCount); end
      dif.Pause_Req = 1'b0;
      cyc();
      checks++; if (dif.Marching !== 1'b1) begin errors++; $display("FAIL unpause: got %b expected 1", dif.Marching); end
      tick(s);
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL resume_held: got %b expected 1", s); end
   endtask

   task automatic test_over();
      int   f0;
      logic s;
      kill(18);
      dif.Alien_Killed = 1'b1;
      dif.Reached_Bottom = 1'b1;
      cyc();
      dif.Alien_Killed = 1'b0;
      dif.Reached_Bottom = 1'b0;
      checks++; if (dif.Game_Over !== 1'b1) begin errors++; $display("FAIL over_enter: got %b expected 1", dif.Game_Over); end
      checks++; if (dif.Marching !== 1'b0) begin errors++; $display("FAIL over_march: got %b expected 0", dif.Marching); end
      checks++; if (dif.AliveCount !== 6'd0) begin errors++; $display("FAIL over_alive: got %0d expected 0", dif.AliveCount); end
      f0 = fr_cnt;
      repeat (95) tick(s);
      checks++; if (dif.Game_Over !== 1'b1 || fr_cnt - f0 !== 0) begin errors++; $display("FAIL over_hold: got over %b resets %0d expected 1 0", dif.Game_Over, fr_cnt - f0); end
      checks++; if (dif.Wave !== 4'd15) begin errors++; $display("FAIL over_wave: got %0d expected 15", dif.Wave); end
   endtask

   task automatic test_restart();
      int f0;
      f0 = fr_cnt;
      dif.Start = 1'b1;
      cyc();
      dif.Start = 1'b0;
      checks++; if (dif.Wave !== 4'd0) begin errors++; $display("FAIL restart_wave: got %0d expected 0", dif.Wave); end
      checks++; if (dif.Formation_Reset !== 1'b1 || dif.Game_Over !== 1'b0) begin errors++; $display("FAIL restart_load: got frst %b over %b expected 1 0", dif.Formation_Reset, dif.Game_Over); end
      checks++; if (dif.AliveCount !== 6'd40) begin errors++; $display("FAIL restart_alive: got %0d expected 40", dif.AliveCount); end
      cyc();
      dif.Start = 1'b1;
      cyc();
      dif.Start = 1'b0;
      cyc();
      checks++; if (fr_cnt - f0 !== 1 || dif.Marching !== 1'b1) begin errors++; $display("FAIL start_ignored: got resets %0d march %b expected 1 1", fr_cnt - f0, dif.Marching); end
   endtask

   task automatic test_reset_mid();
      logic s;
      kill(38);
      tick(s);
      tick(s);
      dif.Frame_Tick = 1'b1;
      cyc();
      dif.Frame_Tick = 1'b0;
      checks++; if (dif.Step !== 1'b1) begin errors++; $display("FAIL premid_step: got %b expected 1", dif.Step); end
      #2;
      Reset_n = 1'b0;
      #1;
      checks++; if (dif.Step !== 1'b0) begin errors++; $display("FAIL mid_step: got %b expected 0", dif.Step); end
      checks++; if (dif.Marching !== 1'b0) begin errors++; $display("FAIL mid_march: got %b expected 0", dif.Marching); end
      checks++; if (dif.AliveCount !== 6'd40) begin errors++; $display("FAIL mid_alive: got %0d expected 40", dif.AliveCount); end
      checks++; if (dif.Formation_Reset !== 1'b0 || dif.Game_Over !== 1'b0 || dif.Wave !== 4'd0) begin errors++; $display("FAIL mid_misc: got frst %b over %b wave %0d expected 0 0 0", dif.Formation_Reset, dif.Game_Over, dif.Wave); end
      cyc();
      Reset_n = 1'b1;
      cyc();
   endtask

   initial begin
      test_reset();
      test_start_period();
      test_fast_period();
      test_clear_wave();
      test_wave_clamp();
      test_pause();
      test_over();
      test_restart();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
